// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared CPU definitions used by the writeback stage and its interface.
//   wb_state_t  : writeback control state (RUN, SQUASH)
//   REG_ADDR_W  : register-file address width
//   DATA_W      : datapath width
package cpu_pkg;

  localparam int REG_ADDR_W = 6;
  localparam int DATA_W     = 32;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_stage_if.sv
// wb_stage_if
// Bundle between the EX/WB pipeline register side (master) and the
// writeback stage (slave).
//   master drives : in_valid, branchN, branchZ, jump, jumpMem, N, Z,
//                   memToReg, pcReg, regWrt, alu, dataMem, adder, rd
//   slave drives  : rf_we, rf_waddr, rf_wdata, pc_redirect, pc_target,
//                   flush, retired
interface wb_stage_if;
  import cpu_pkg::*;

  // EX/WB register outputs
  logic                  in_valid;
  logic                  branchN;
  logic                  branchZ;
  logic                  jump;
  logic                  jumpMem;
  logic                  N;
  logic                  Z;
  logic                  memToReg;
  logic                  pcReg;
  logic                  regWrt;
  logic [DATA_W-1:0]     alu;
  logic [DATA_W-1:0]     dataMem;
  logic [DATA_W-1:0]     adder;
  logic [REG_ADDR_W-1:0] rd;

  // Writeback stage results
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;
  logic                  pc_redirect;
  logic [DATA_W-1:0]     pc_target;
  logic                  flush;
  logic [DATA_W-1:0]     retired;

  modport master (
    output in_valid, branchN, branchZ, jump, jumpMem, N, Z,
           memToReg, pcReg, regWrt, alu, dataMem, adder, rd,
    input  rf_we, rf_waddr, rf_wdata, pc_redirect, pc_target, flush, retired
  );

  modport slave (
    input  in_valid, branchN, branchZ, jump, jumpMem, N, Z,
           memToReg, pcReg, regWrt, alu, dataMem, adder, rd,
    output rf_we, rf_waddr, rf_wdata, pc_redirect, pc_target, flush, retired
  );

endinterface

// File: rtl/wb_stage_pc_redirect_ctl.sv
// pc_redirect_ctl
// RUN/SQUASH controller for the writeback stage. A live taken instruction
// in RUN produces a one-cycle registered redirect and then holds the stage
// in SQUASH for SQUASH_CYCLES cycles.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   live        : a valid instruction is being accepted this cycle
//   taken       : that instruction changes control flow
//   target      : its redirect target
//   flush       : high while in SQUASH
//   pcRedirect  : one-cycle redirect pulse (registered)
//   pcTarget    : redirect target, meaningful while pcRedirect=1 (registered)
module pc_redirect_ctl
  import cpu_pkg::*;
#(
  parameter int SQUASH_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              live,
  input  logic              taken,
  input  logic [DATA_W-1:0] target,
  output logic              flush,
  output logic              pcRedirect,
  output logic [DATA_W-1:0] pcTarget
);

  localparam int CNT_W = $clog2(SQUASH_CYCLES + 1);

  wb_state_t         state;
  wb_state_t         stateNext;
  logic [CNT_W-1:0]  squashCnt;
  logic [CNT_W-1:0]  squashCntNext;
  logic              redirectNext;
  logic [DATA_W-1:0] targetNext;

  // State, counter and redirect registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      squashCnt  <= '0;
      pcRedirect <= 1'b0;
      pcTarget   <= '0;
    end else begin
      state      <= stateNext;
      squashCnt  <= squashCntNext;
      pcRedirect <= redirectNext;
      pcTarget   <= targetNext;
    end
  end

  // Next-state logic. The target register holds its last value outside a
  // redirect; consumers only look at it while pcRedirect is high.
  always_comb begin
    stateNext     = state;
    squashCntNext = squashCnt;
    redirectNext  = 1'b0;
    targetNext    = pcTarget;
    case (state)
      RUN: begin
        if (live && taken) begin
          stateNext     = SQUASH;
          squashCntNext = CNT_W'(SQUASH_CYCLES);
          redirectNext  = 1'b1;
          targetNext    = target;
        end
      end
      SQUASH: begin
        squashCntNext = squashCnt - CNT_W'(1);
        // Counter value 1 marks the last squash cycle.
        if (squashCnt == CNT_W'(1)) begin
          stateNext = RUN;
        end
      end
      default: begin
        stateNext = RUN;
      end
    endcase
  end

  // Outputs
  always_comb begin
    flush = (state == SQUASH);
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage
// Writeback and control-flow resolution stage fed by the EX/WB register.
// Selects register-file write data, resolves jumps and N/Z branches into a
// registered PC redirect, squashes younger instructions for SQUASH_CYCLES
// cycles after a redirect, and counts retired instructions.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : wb_stage_if slave modport
//              inputs : in_valid, branchN/Z, jump, jumpMem, N, Z, memToReg,
//                       pcReg, regWrt, alu, dataMem, adder, rd
//              outputs: rf_we/rf_waddr/rf_wdata (combinational),
//                       pc_redirect/pc_target/flush/retired (registered)
module wb_stage
  import cpu_pkg::*;
#(
  parameter int SQUASH_CYCLES = 3
) (
  input logic       clk,
  input logic       rst,
  wb_stage_if.slave bus
);

  logic              live;
  logic              taken;
  logic              flushInt;
  logic [DATA_W-1:0] target;
  logic [DATA_W-1:0] retiredCnt;

  // An instruction only counts while the stage is not squashing.
  assign live  = bus.in_valid & ~flushInt;
  assign taken = bus.jumpMem | bus.jump | (bus.branchZ & bus.Z) | (bus.branchN & bus.N);
  // jump and both branches share the ALU result as target, so only
  // jumpMem needs to be distinguished.
  assign target = bus.jumpMem ? bus.dataMem : bus.alu;

  // Register-file write port; rd=0 is an ordinary register.
  assign bus.rf_we    = live & bus.regWrt;
  assign bus.rf_waddr = bus.rd;
  assign bus.rf_wdata = bus.memToReg ? bus.dataMem : (bus.pcReg ? bus.adder : bus.alu);

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retiredCnt <= '0;
    end else if (live) begin
      retiredCnt <= retiredCnt + DATA_W'(1);
    end
  end

  assign bus.retired = retiredCnt;
  assign bus.flush   = flushInt;

  pc_redirect_ctl #(
    .SQUASH_CYCLES(SQUASH_CYCLES)
  ) u_redirectCtl (
    .clk       (clk),
    .rst       (rst),
    .live      (live),
    .taken     (taken),
    .target    (target),
    .flush     (flushInt),
    .pcRedirect(bus.pc_redirect),
    .pcTarget  (bus.pc_target)
  );

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage
// Self-checking bench for wb_stage: table-driven writeback vectors,
// hand-written redirect/squash/reset/wrap sequences and a randomized run
// against a cycle-level reference model of the stage's rules.
module tb_wb_stage;
  import cpu_pkg::*;

  localparam int SQ = 3;

  typedef struct {
    logic        v;
    logic        bN;
    logic        bZ;
    logic        j;
    logic        jM;
    logic        n;
    logic        z;
    logic        m2r;
    logic        pcR;
    logic        rW;
    logic [31:0] alu;
    logic [31:0] dm;
    logic [31:0] add;
    logic [5:0]  rd;
  } inVec_t;

  typedef struct {
    inVec_t      in;
    logic        expWe;
    logic [31:0] expWdata;
  } vecRec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wb_stage_if bus ();

  wb_stage #(.SQUASH_CYCLES(SQ)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model: number of squash cycles still to come, plus the
  // registered outputs the stage should show after the last edge.
  int          mSquashLeft;
  logic        mRedirect;
  logic [31:0] mTarget;
  logic [31:0] mRetired;
  inVec_t      curIn;
  logic        expLive;
  logic        expTaken;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mSquashLeft = 0;
    mRedirect   = 1'b0;
    mTarget     = 32'h0;
    mRetired    = 32'h0;
  endtask

  function automatic inVec_t bubble();
    inVec_t x;
    x = '{default: '0};
    return x;
  endfunction

  // Drive inputs (called away from the rising edge) and check the
  // combinational write port against the model.
  task automatic applyIn(input inVec_t x);
    logic [31:0] expData;
    curIn = x;
    bus.in_valid = x.v;
    bus.branchN  = x.bN;
    bus.branchZ  = x.bZ;
    bus.jump     = x.j;
    bus.jumpMem  = x.jM;
    bus.N        = x.n;
    bus.Z        = x.z;
    bus.memToReg = x.m2r;
    bus.pcReg    = x.pcR;
    bus.regWrt   = x.rW;
    bus.alu      = x.alu;
    bus.dataMem  = x.dm;
    bus.adder    = x.add;
    bus.rd       = x.rd;
    #1;
    expLive  = x.v && (mSquashLeft == 0);
    expTaken = x.jM || x.j || (x.bZ && x.z) || (x.bN && x.n);
    if (x.m2r)      expData = x.dm;
    else if (x.pcR) expData = x.add;
    else            expData = x.alu;
    chk("rf_we", 32'(bus.rf_we), 32'(expLive && x.rW));
    chk("rf_waddr", 32'(bus.rf_waddr), 32'(x.rd));
    chk("rf_wdata", bus.rf_wdata, expData);
  endtask

  // Clock the stage, advance the model, check the registered outputs.
  task automatic finishCycle();
    @(posedge clk);
    if (mSquashLeft > 0) begin
      mSquashLeft--;
      mRedirect = 1'b0;
    end else if (expLive && expTaken) begin
      mRedirect   = 1'b1;
      mTarget     = curIn.jM ? curIn.dm : curIn.alu;
      mSquashLeft = SQ;
    end else begin
      mRedirect = 1'b0;
    end
    if (expLive) mRetired = mRetired + 32'd1;
    @(negedge clk);
    chk("flush", 32'(bus.flush), 32'(mSquashLeft > 0));
    chk("pc_redirect", 32'(bus.pc_redirect), 32'(mRedirect));
    if (mRedirect) chk("pc_target", bus.pc_target, mTarget);
    chk("retired", bus.retired, mRetired);
    $display("[TB] txn v=%0b live=%0b taken=%0b redir=%0b tgt=%h flush=%0b retired=%0d",
             curIn.v, expLive, expTaken, bus.pc_redirect, bus.pc_target, bus.flush, bus.retired);
  endtask

  task automatic runCycle(input inVec_t x);
    applyIn(x);
    finishCycle();
  endtask

  function automatic inVec_t aluOp(input logic [31:0] a, input logic [5:0] r);
    inVec_t x;
    x = '{default: '0};
    x.v = 1'b1;
    x.rW = 1'b1;
    x.alu = a;
    x.rd = r;
    return x;
  endfunction

  vecRec_t tbl[6];

  initial begin
    inVec_t x;

    // Writeback vectors: {inputs, expected rf_we, expected rf_wdata}
    x = aluOp(32'h1234, 6'd5);
    tbl[0] = '{in: x, expWe: 1'b1, expWdata: 32'h1234};
    x = aluOp(32'h1, 6'd7); x.m2r = 1'b1; x.pcR = 1'b1; x.dm = 32'hAAAA; x.add = 32'hBBBB;
    tbl[1] = '{in: x, expWe: 1'b1, expWdata: 32'hAAAA};
    x.m2r = 1'b0;
    tbl[2] = '{in: x, expWe: 1'b1, expWdata: 32'hBBBB};
    x = aluOp(32'hCAFE_0000, 6'd0);
    tbl[3] = '{in: x, expWe: 1'b1, expWdata: 32'hCAFE_0000};
    x = aluOp(32'h5555, 6'd9); x.rW = 1'b0;
    tbl[4] = '{in: x, expWe: 1'b0, expWdata: 32'h5555};
    x = aluOp(32'h7777, 6'd63); x.v = 1'b0;
    tbl[5] = '{in: x, expWe: 1'b0, expWdata: 32'h7777};

    // Reset state
    modelReset();
    applyIn(bubble());
    chk("rst_flush", 32'(bus.flush), 32'h0);
    chk("rst_pc_redirect", 32'(bus.pc_redirect), 32'h0);
    chk("rst_pc_target", bus.pc_target, 32'h0);
    chk("rst_retired", bus.retired, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven writeback vectors
    for (int i = 0; i < 6; i++) begin
      applyIn(tbl[i].in);
      chk($sformatf("tbl%0d_we", i), 32'(bus.rf_we), 32'(tbl[i].expWe));
      chk($sformatf("tbl%0d_wdata", i), bus.rf_wdata, tbl[i].expWdata);
      finishCycle();
    end
    chk("retired_after_tbl", bus.retired, 32'd5);

    // Taken branchZ: redirect next cycle, then SQ squashed cycles
    x = aluOp(32'h40, 6'd1); x.bZ = 1'b1; x.z = 1'b1;
    runCycle(x);
    chk("bz_redirect", 32'(bus.pc_redirect), 32'h1);
    chk("bz_target", bus.pc_target, 32'h40);
    for (int i = 0; i < SQ; i++) begin
      x = aluOp(32'h100 + 32'(i), 6'd2); x.j = 1'b1;
      applyIn(x);
      chk($sformatf("squash%0d_we", i), 32'(bus.rf_we), 32'h0);
      chk($sformatf("squash%0d_flush", i), 32'(bus.flush), 32'h1);
      finishCycle();
      chk($sformatf("squash%0d_noredir", i), 32'(bus.pc_redirect), 32'h0);
    end
    chk("squash_end_flush", 32'(bus.flush), 32'h0);
    chk("squash_retired", bus.retired, 32'd6);

    // Branch on N with N clear: no redirect
    x = aluOp(32'h44, 6'd3); x.bN = 1'b1; x.n = 1'b0; x.z = 1'b1;
    runCycle(x);
    chk("bn_not_taken", 32'(bus.pc_redirect), 32'h0);

    // jumpMem beats jump
    x = aluOp(32'h40, 6'd4); x.jM = 1'b1; x.j = 1'b1; x.dm = 32'h80;
    runCycle(x);
    chk("prio_target", bus.pc_target, 32'h80);
    for (int i = 0; i < SQ; i++) runCycle(bubble());

    // Reset in the second flush cycle
    x = aluOp(32'h200, 6'd5); x.j = 1'b1;
    runCycle(x);
    runCycle(bubble());
    chk("pre_rst_flush", 32'(bus.flush), 32'h1);
    rst = 1'b1;
    #1;
    modelReset();
    chk("midrst_flush", 32'(bus.flush), 32'h0);
    chk("midrst_pc_redirect", 32'(bus.pc_redirect), 32'h0);
    chk("midrst_retired", bus.retired, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    x = aluOp(32'h3333, 6'd10);
    applyIn(x);
    chk("post_rst_we", 32'(bus.rf_we), 32'h1);
    finishCycle();
    chk("post_rst_retired", bus.retired, 32'd1);

    // Retired counter wrap
    force dut.retiredCnt = 32'hFFFF_FFFF;
    #1;
    release dut.retiredCnt;
    mRetired = 32'hFFFF_FFFF;
    runCycle(aluOp(32'h1, 6'd11));
    chk("wrap_retired", bus.retired, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 200; i++) begin
      x.v   = ($urandom_range(0, 3) != 0);
      x.bN  = ($urandom_range(0, 5) == 0);
      x.bZ  = ($urandom_range(0, 5) == 0);
      x.j   = ($urandom_range(0, 9) == 0);
      x.jM  = ($urandom_range(0, 9) == 0);
      x.n   = 1'($urandom_range(0, 1));
      x.z   = 1'($urandom_range(0, 1));
      x.m2r = 1'($urandom_range(0, 1));
      x.pcR = 1'($urandom_range(0, 1));
      x.rW  = 1'($urandom_range(0, 1));
      x.alu = $urandom;
      x.dm  = $urandom;
      x.add = $urandom;
      x.rd  = 6'($urandom_range(0, 63));
      runCycle(x);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback and control-flow resolution stage; it consumes the EX/WB pipeline register outputs of the CPU. Each cycle it selects the register-file write data, resolves jumps and N/Z branches into a registered PC redirect, and squashes younger in-flight instructions for a fixed number of cycles after a redirect. It also keeps a retired-instruction count.

## Interface
Parameters:
- SQUASH_CYCLES, 3, number of cycles after a redirect during which incoming instructions are discarded; legal range 1..15

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  EX/WB register holds a real instruction (0 = bubble)
- branchN, branchZ, jump, jumpMem  in  1 each  control-flow controls from EX/WB
- N, Z  in  1 each  ALU flags from EX/WB
- memToReg, pcReg, regWrt  in  1 each  writeback controls from EX/WB
- alu  in  32  ALU result, also the jump/branch target
- dataMem  in  32  data-memory read value, also the jumpMem target
- adder  in  32  PC+immediate value
- rd  in  6  destination register
- rf_we  out  1  register-file write enable (combinational)
- rf_waddr  out  6  register-file write address (combinational, equals rd)
- rf_wdata  out  32  register-file write data (combinational)
- pc_redirect  out  1  one-cycle pulse that loads the fetch PC (registered)
- pc_target  out  32  redirect target, valid while pc_redirect=1 (registered)
- flush  out  1  high while the stage is in SQUASH (registered)
- retired  out  32  count of retired instructions (registered)

## Operation
- live = in_valid & (state == RUN).
- Write data: memToReg ? dataMem : (pcReg ? adder : alu). memToReg has priority over pcReg.
- rf_we = live & regWrt. rd = 0 is writable, because the ISA has no hard-wired zero register.
- taken = jumpMem | jump | (branchZ & Z) | (branchN & N).
- Target: jumpMem ? dataMem : alu. When several controls are set, priority is jumpMem > jump > branchZ > branchN.
- FSM states: RUN, SQUASH.
  - RUN with live & taken: on the next edge, pc_redirect=1, pc_target=target, state=SQUASH, squash counter=SQUASH_CYCLES.
  - SQUASH: each cycle the counter decrements; when the counter reaches 1, the next state is RUN.
  - While in SQUASH, valid instructions are discarded: no rf_we, no redirect, no retire count.
- pc_redirect is a single-cycle pulse and is never asserted twice in a row.
- flush = (state == SQUASH).
- retired increments by 1 on each live instruction, including the taken instruction itself. It wraps from 0xFFFFFFFF to 0.
- Bubbles (in_valid=0) in RUN have no effect.
- Reset (asynchronous, any time, including mid-SQUASH):
  - state=RUN, counter=0
  - pc_redirect=0, pc_target=0, flush=0, retired=0
  - Combinational outputs follow their inputs gated by RUN, so after reset they are live immediately.

## Timing
- Register write: same cycle the instruction is presented (zero latency); the register file captures it at the end of that cycle.
- Redirect: taken instruction presented in cycle T gives pc_redirect=1 in cycle T+1.
- flush is high in cycles T+1 .. T+SQUASH_CYCLES; instructions presented in those cycles are squashed.
- RUN resumes in cycle T+SQUASH_CYCLES+1, so a taken branch may redirect again in T+SQUASH_CYCLES+2.
- retired updates at the end of cycle T and is visible in T+1.

## Structure
- Shared package cpu_pkg holds:
  - the wb_state_t enum (RUN, SQUASH)
  - the widths REG_ADDR_W=6 and DATA_W=32
- One sub-module, pc_redirect_ctl, holds:
  - the FSM and squash counter ($clog2(SQUASH_CYCLES+1) bits)
  - the pc_redirect/pc_target registers
  - inputs: live, taken, target; outputs: flush and the redirect pair
- The write mux and the retired counter stay in wb_stage.

## Test plan
- Reset then ALU op: alu=0x1234, regWrt=1, rd=5, memToReg=pcReg=0 -> rf_we=1, rf_waddr=5, rf_wdata=0x1234 same cycle; retired=1 next cycle.
- Mux priority: memToReg=1, pcReg=1, dataMem=0xAAAA, adder=0xBBBB -> rf_wdata=0xAAAA. With memToReg=0 -> 0xBBBB.
- Branch resolution:
  - branchZ=1, Z=1, alu=0x40 -> pc_redirect pulse with pc_target=0x40 one cycle later, flush high 3 cycles, and valid instructions in those cycles do not assert rf_we or advance retired.
  - branchN=1, N=0 -> no redirect.
- Priority: jumpMem=1, jump=1, dataMem=0x80, alu=0x40 -> pc_target=0x80. A taken branch presented during SQUASH -> ignored.
- Reset mid-SQUASH: assert rst in second flush cycle -> flush, pc_redirect, retired go 0 immediately; the first valid instruction after reset writes normally.
- Wrap: preload retired to 0xFFFFFFFF via 2^32-1 instructions (or a force), one more live instruction -> retired=0.
